if_fetcher: RTL



---
 rtl/if_fetcher_pkg.sv | 27 ++
 rtl/if_fetcher_if.sv | 26 ++
 rtl/if_fetcher_instr_queue.sv | 63 ++++++
 rtl/if_fetcher.sv | 90 +++++++++
 4 files changed

// File: rtl/if_fetcher_pkg.sv
// Shared types, constants and the static branch predictor for the fetch stage.
package if_fetcher_pkg;

  localparam int         IQ_DEPTH_DEFAULT = 16;
  localparam int         IQ_IDX_W_DEFAULT = 4;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pred_pc;
  } iq_entry_t;

  // JAL is the only statically predicted control transfer; everything else falls through.
  function automatic logic [31:0] predict_next_pc(input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] imm;
    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    if (instr[6:0] == OPCODE_JAL) return pc + imm;
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetcher_if.sv
// Fetch-stage bus: icache request/response, decoder-facing queue head and redirect.
interface if_fetcher_if;

  logic        rdy_to_icache;
  logic [31:0] pc_to_icache;
  logic        instr_valid_from_icache;
  logic [31:0] instr_from_icache;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic [31:0] iq_pred_pc;
  logic        dec_pop;
  logic        jump_en;
  logic [31:0] jump_pc;

  modport master (
    output rdy_to_icache, pc_to_icache, iq_valid, iq_instr, iq_pc, iq_pred_pc,
    input  instr_valid_from_icache, instr_from_icache, dec_pop, jump_en, jump_pc
  );

  modport slave (
    input  rdy_to_icache, pc_to_icache, iq_valid, iq_instr, iq_pc, iq_pred_pc,
    output instr_valid_from_icache, instr_from_icache, dec_pop, jump_en, jump_pc
  );

endinterface

// File: rtl/if_fetcher_instr_queue.sv
// Circular instruction queue of {pc, instr, pred_pc}; flush empties it in one cycle.
module if_fetcher_instr_queue
  import if_fetcher_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int IDX_W = IQ_IDX_W_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  iq_entry_t push_data,
  output logic      full,
  output logic      empty,
  output iq_entry_t head_data
);

  iq_entry_t        mem_q [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (IDX_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];

  // Pointers are IDX_W wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    do_push = push & ~full & ~flush;
    do_pop  = pop & ~empty & ~flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + IDX_W'(1);
      if (do_pop)  head_d = head_q + IDX_W'(1);
      count_d = count_q + (IDX_W+1)'(do_push) - (IDX_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= push_data;
  end

endmodule

// File: rtl/if_fetcher.sv
// Instruction fetch stage: owns the fetch PC, predicts JALs and feeds the decoder queue.
//
// state    | meaning
// ST_RUN   | normal fetch; hits are enqueued and pc advances to the prediction
// ST_DRAIN | redirect arrived during a refill; hold pc until the refill returns, then jump
module if_fetcher
  import if_fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH = IQ_DEPTH_DEFAULT,
  parameter int          IQ_IDX_W = IQ_IDX_W_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  if_fetcher_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pending_q;
  logic [31:0]  pred_pc;
  logic         iq_full, iq_empty;
  logic         miss, accept, iq_pop, iq_flush;
  iq_entry_t    push_entry, head_entry;

  assign pred_pc    = predict_next_pc(pc_q, bus.instr_from_icache);
  assign push_entry = '{pc: pc_q, instr: bus.instr_from_icache, pred_pc: pred_pc};

  assign bus.rdy_to_icache = (state_q == ST_DRAIN) | ~iq_full;
  assign bus.pc_to_icache  = pc_q;
  assign bus.iq_valid      = ~iq_empty;
  assign bus.iq_pc         = head_entry.pc;
  assign bus.iq_instr      = head_entry.instr;
  assign bus.iq_pred_pc    = head_entry.pred_pc;

  assign miss     = bus.rdy_to_icache & ~bus.instr_valid_from_icache;
  assign accept   = rdy & bus.rdy_to_icache & bus.instr_valid_from_icache &
                    (state_q == ST_RUN) & ~bus.jump_en & ~iq_full;
  assign iq_pop   = rdy & bus.dec_pop & ~bus.jump_en;
  assign iq_flush = rdy & bus.jump_en;

  // pc must stay put while a refill is outstanding: the icache latched its index/tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      pending_q <= '0;
    end else if (rdy) begin
      case (state_q)
        ST_RUN: begin
          if (bus.jump_en) begin
            if (miss) begin
              pending_q <= bus.jump_pc;
              state_q   <= ST_DRAIN;
            end else begin
              pc_q <= bus.jump_pc;
            end
          end else if (accept) begin
            pc_q <= pred_pc;
          end
        end
        ST_DRAIN: begin
          if (bus.instr_valid_from_icache) begin
            pc_q    <= bus.jump_en ? bus.jump_pc : pending_q;
            state_q <= ST_RUN;
          end else if (bus.jump_en) begin
            pending_q <= bus.jump_pc;
          end
        end
      endcase
    end
  end

  if_fetcher_instr_queue #(
    .DEPTH (IQ_DEPTH),
    .IDX_W (IQ_IDX_W)
  ) u_instr_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (iq_pop),
    .flush     (iq_flush),
    .push_data (push_entry),
    .full      (iq_full),
    .empty     (iq_empty),
    .head_data (head_entry)
  );

endmodule
